// File: rtl/digit_scan_controller.sv
// Scan sequencer for a 4-digit 7-segment display: steps the anode decoder
// select through digits 0..3 with a dwell time and a blanked guard gap.
module digit_scan_controller #(
  parameter int DWELL = 50000,
  parameter int GUARD = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic [15:0] Digits,
  input  logic [3:0]  BlankMask,
  output logic [1:0]  Sel,
  output logic        SelEn,
  output logic [3:0]  DigitOut,
  output logic        FrameStart
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] GUARD_LAST = (GUARD > 0) ? 16'(GUARD - 1) : 16'd0;
  localparam bit          HAS_GUARD  = (GUARD > 0);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        sel_en_q, sel_en_d;
  logic [3:0]  digit_q, digit_d;
  logic        frame_q, frame_d;
  logic [15:0] dig_lat_q, dig_lat_d;
  logic [3:0]  mask_lat_q, mask_lat_d;

  logic        dwell_end;
  logic        guard_end;
  logic        advance;
  logic [1:0]  next_sel;

  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] idx);
    nibble_of = word[{idx, 2'b00} +: 4];
  endfunction

  assign dwell_end = (cnt_q == DWELL_LAST);
  assign guard_end = (cnt_q == GUARD_LAST);
  assign next_sel  = sel_q + 2'd1;
  assign advance   = Enable && (((state_q == ST_ACTIVE) && dwell_end && !HAS_GUARD) ||
                                ((state_q == ST_GUARD) && guard_end));

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Enable) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!Enable) begin
          state_d = ST_IDLE;
        end else if (dwell_end) begin
          state_d = HAS_GUARD ? ST_GUARD : ST_ACTIVE;
        end
      end
      ST_GUARD: begin
        if (!Enable) begin
          state_d = ST_IDLE;
        end else if (guard_end) begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    sel_en_d   = sel_en_q;
    digit_d    = digit_q;
    frame_d    = 1'b0;
    dig_lat_d  = dig_lat_q;
    mask_lat_d = mask_lat_q;

    case (state_q)
      ST_IDLE: begin
        sel_en_d = 1'b0;
        if (Enable) begin
          sel_d      = 2'd0;
          cnt_d      = 16'd0;
          dig_lat_d  = Digits;
          mask_lat_d = BlankMask;
          digit_d    = Digits[3:0];
          sel_en_d   = ~BlankMask[0];
          frame_d    = 1'b1;
        end
      end
      ST_ACTIVE, ST_GUARD: begin
        if (!Enable) begin
          sel_en_d = 1'b0;
          sel_d    = 2'd0;
          cnt_d    = 16'd0;
        end else if (advance) begin
          sel_d = next_sel;
          cnt_d = 16'd0;
          // Wrapping back to digit 0 is the one place a new frame is latched.
          if (sel_q == 2'd3) begin
            dig_lat_d  = Digits;
            mask_lat_d = BlankMask;
            digit_d    = Digits[3:0];
            sel_en_d   = ~BlankMask[0];
            frame_d    = 1'b1;
          end else begin
            digit_d  = nibble_of(dig_lat_q, next_sel);
            sel_en_d = ~mask_lat_q[next_sel];
          end
        end else if ((state_q == ST_ACTIVE) && dwell_end) begin
          sel_en_d = 1'b0;
          cnt_d    = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        sel_en_d = 1'b0;
        sel_d    = 2'd0;
        cnt_d    = 16'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q      <= 16'd0;
      sel_q      <= 2'd0;
      sel_en_q   <= 1'b0;
      digit_q    <= 4'd0;
      frame_q    <= 1'b0;
      dig_lat_q  <= 16'd0;
      mask_lat_q <= 4'd0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      sel_en_q   <= sel_en_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      dig_lat_q  <= dig_lat_d;
      mask_lat_q <= mask_lat_d;
    end
  end

  assign Sel        = sel_q;
  assign SelEn      = sel_en_q;
  assign DigitOut   = digit_q;
  assign FrameStart = frame_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Bench for digit_scan_controller: two builds (GUARD=2 and GUARD=0) driven by
// the same inputs and checked every cycle against a frame-position model.
module tb_digit_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  blank_mask;

  logic [1:0]  sel_a, sel_b;
  logic        en_a, en_b;
  logic [3:0]  dig_a, dig_b;
  logic        fs_a, fs_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_m    = 0;
  bit chk_on   = 1'b0;
  int ena_cnt  = 0;
  int enb_cnt  = 0;

  always #5 clk = ~clk;

  digit_scan_controller #(.DWELL(4), .GUARD(2)) dut_a (
    .Clk(clk), .Rst(rst), .Enable(enable), .Digits(digits), .BlankMask(blank_mask),
    .Sel(sel_a), .SelEn(en_a), .DigitOut(dig_a), .FrameStart(fs_a)
  );

  digit_scan_controller #(.DWELL(4), .GUARD(0)) dut_b (
    .Clk(clk), .Rst(rst), .Enable(enable), .Digits(digits), .BlankMask(blank_mask),
    .Sel(sel_b), .SelEn(en_b), .DigitOut(dig_b), .FrameStart(fs_b)
  );

  // Model: a running display is just a position within a frame of
  // 4*(DWELL+GUARD) cycles; slot and offset follow from division.
  int          dw[2] = '{4, 4};
  int          gd[2] = '{2, 0};
  bit          run[2];
  int          pos[2];
  logic [15:0] ld[2];
  logic [3:0]  lm[2];
  logic [1:0]  m_sel[2];
  logic        m_en[2];
  logic [3:0]  m_dig[2];
  logic        m_fs[2];

  task automatic show(input int k);
    int p, slot, off;
    p    = dw[k] + gd[k];
    slot = pos[k] / p;
    off  = pos[k] % p;
    m_sel[k] = 2'(slot);
    m_en[k]  = (off < dw[k]) && !lm[k][slot];
    m_dig[k] = ld[k][slot*4 +: 4];
    m_fs[k]  = (pos[k] == 0);
  endtask

  always @(posedge clk) begin
    cyc_m++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run[k] = 0; pos[k] = 0; ld[k] = '0; lm[k] = '0;
        m_sel[k] = '0; m_en[k] = 0; m_dig[k] = '0; m_fs[k] = 0;
        chk_on = 1'b1;
      end else if (!run[k]) begin
        m_en[k] = 0; m_fs[k] = 0;
        if (enable) begin
          run[k] = 1; pos[k] = 0; ld[k] = digits; lm[k] = blank_mask;
          show(k);
        end
      end else if (!enable) begin
        run[k] = 0; m_en[k] = 0; m_sel[k] = '0; m_fs[k] = 0;
      end else begin
        pos[k] = (pos[k] + 1) % (4 * (dw[k] + gd[k]));
        if (pos[k] == 0) begin
          ld[k] = digits; lm[k] = blank_mask;
        end
        show(k);
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [1:0] s, input logic e,
                          input logic [3:0] d, input logic f);
    n_checks++;
    if ({s, e, d, f} !== {m_sel[k], m_en[k], m_dig[k], m_fs[k]}) begin
      n_fail++;
      $display("FAIL model_cmp dut%0d cyc=%0d got sel=%0d en=%b dig=%h fs=%b exp sel=%0d en=%b dig=%h fs=%b",
               k, cyc_m, s, e, d, f, m_sel[k], m_en[k], m_dig[k], m_fs[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst(0, sel_a, en_a, dig_a, fs_a);
      cmp_inst(1, sel_b, en_b, dig_b, fs_b);
      if (cyc_m >= 52 && cyc_m <= 75 && en_a === 1'b1) ena_cnt++;
      if (cyc_m >= 4 && cyc_m <= 19 && en_b === 1'b1) enb_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %h expected %h", name, cyc_m, act, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc_m < n) @(negedge clk);
  endtask

  // Packs Sel, SelEn, DigitOut, FrameStart of DUT A as {sel,en,dig,fs}.
  function automatic logic [31:0] pa();
    return 32'({sel_a, en_a, dig_a, fs_a});
  endfunction
  function automatic logic [31:0] pb();
    return 32'({sel_b, en_b, dig_b, fs_b});
  endfunction
  function automatic logic [31:0] exp4(input int s, input bit e, input int d, input bit f);
    return 32'({2'(s), e, 4'(d), f});
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b1; digits = 16'h4321; blank_mask = 4'b0000;
    goto(3);
    chk("reset_a", pa(), exp4(0, 0, 0, 0));
    chk("reset_b", pb(), exp4(0, 0, 0, 0));
    rst = 1'b0;
    goto(4);
    chk("start_a", pa(), exp4(0, 1, 1, 1));
    chk("start_b", pb(), exp4(0, 1, 1, 1));
    goto(8);
    chk("guard0_a", pa(), exp4(0, 0, 1, 0));
    chk("nog_sel1_b", pb(), exp4(1, 1, 2, 0));
    goto(10);
    chk("sel1_a", pa(), exp4(1, 1, 2, 0));
    goto(11);
    digits = 16'hABCD;
    goto(16);
    chk("tear_sel2_a", pa(), exp4(2, 1, 3, 0));
    goto(20);
    chk("frame2_b", pb(), exp4(0, 1, 4'hD, 1));
    goto(22);
    chk("tear_sel3_a", pa(), exp4(3, 1, 4, 0));
    goto(28);
    chk("frame2_a", pa(), exp4(0, 1, 4'hD, 1));
    goto(30);
    blank_mask = 4'b0101;
    goto(34);
    chk("frame2_sel1_a", pa(), exp4(1, 1, 4'hC, 0));
    goto(52);
    chk("blank_sel0_a", pa(), exp4(0, 0, 4'hD, 1));
    goto(58);
    chk("blank_sel1_a", pa(), exp4(1, 1, 4'hC, 0));
    goto(60);
    blank_mask = 4'b0000;
    goto(64);
    chk("blank_sel2_a", pa(), exp4(2, 0, 4'hB, 0));
    goto(70);
    chk("blank_sel3_a", pa(), exp4(3, 1, 4'hA, 0));
    goto(76);
    chk("frame4_a", pa(), exp4(0, 1, 4'hD, 1));
    goto(89);
    chk("pre_disable_a", pa(), exp4(2, 1, 4'hB, 0));
    enable = 1'b0;
    goto(90);
    chk("disabled_a", pa(), exp4(0, 0, 4'hB, 0));
    chk("disabled_b_en", 32'(en_b), 32'd0);
    goto(92);
    digits = 16'h5678;
    enable = 1'b1;
    goto(93);
    chk("reenable_a", pa(), exp4(0, 1, 8, 1));
    chk("reenable_b", pb(), exp4(0, 1, 8, 1));
    goto(97);
    chk("in_guard_a", pa(), exp4(0, 0, 8, 0));
    rst = 1'b1;
    goto(98);
    chk("rst_guard_a", pa(), exp4(0, 0, 0, 0));
    chk("rst_guard_b", pb(), exp4(0, 0, 0, 0));
    goto(100);
    rst = 1'b0;
    goto(101);
    chk("post_rst_a", pa(), exp4(0, 1, 8, 1));
    goto(110);
    chk("blank_frame_en_cycles_a", 32'(ena_cnt), 32'd8);
    chk("nog_frame_en_cycles_b", 32'(enb_cnt), 32'd16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
